// File: rtl/pe_pkg.sv
// Shared PE-side types and default widths used by the ifmap transmit path.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_DATA_SIZE    = 8;
  localparam int DEFAULT_CONFIG_W_BIT = 12;
  localparam int XFER_CNT_W           = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock staging FIFO with registered storage; head is visible only after the write edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    head     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/ifmap_tx.sv
// Streams config_W staged ifmap beats from the GLB-side FIFO to the PE per start request.
// Optional beat counter output xfer_cnt is enabled by defining IFMAP_TX_XFER_CNT_EN.
module ifmap_tx
  import pe_pkg::*;
#(
  parameter int DATA_SIZE    = DEFAULT_DATA_SIZE,
  parameter int IFMAP_NUM    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int CONFIG_W_BIT = DEFAULT_CONFIG_W_BIT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [IFMAP_NUM*DATA_SIZE-1:0] in_data,
  output logic                           in_ready,
  input  logic                           start,
  input  logic [CONFIG_W_BIT-1:0]        config_W,
  output logic [IFMAP_NUM*DATA_SIZE-1:0] ifmap,
  output logic                           ifmap_enable,
  input  logic                           ifmap_ready,
  output logic                           busy,
  output logic                           done
`ifdef IFMAP_TX_XFER_CNT_EN
  ,
  output logic [XFER_CNT_W-1:0]          xfer_cnt
`endif
);

  localparam int W = IFMAP_NUM * DATA_SIZE;

  state_e                  state_q, state_d;
  logic [CONFIG_W_BIT-1:0] remaining_q, remaining_d;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [W-1:0]            fifo_head;
  logic                    fifo_push;
  logic                    beat;

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (beat),
    .din   (in_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Outputs are forced to their idle values while rst is high so an abort never leaks a beat or done.
  always_comb begin
    in_ready     = rst | ~fifo_full;
    fifo_push    = in_valid & ~fifo_full;
    ifmap_enable = ~rst & (state_q == SEND) & ~fifo_empty;
    beat         = ifmap_enable & ifmap_ready;
    ifmap        = fifo_head;
    busy         = ~rst & (state_q == SEND);
    done         = ~rst & (state_q == DONE);
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = config_W;
          state_d     = (config_W == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (beat) begin
          remaining_d = remaining_q - CONFIG_W_BIT'(1);
          if (remaining_q == CONFIG_W_BIT'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

`ifdef IFMAP_TX_XFER_CNT_EN
  logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  // Free-running beat total; wraps naturally at the counter width.
  always_comb begin
    xfer_cnt_d = beat ? xfer_cnt_q + XFER_CNT_W'(1) : xfer_cnt_q;
    xfer_cnt   = xfer_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_ifmap_tx.sv
// Self-checking bench for ifmap_tx: queue-based reference model plus directed transfer scenarios.
module tb_ifmap_tx;

  localparam int DEPTH  = 16;
  localparam int M_IDLE = 0;
  localparam int M_SEND = 1;
  localparam int M_DONE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        start = 1'b0;
  logic [11:0] config_W = 12'd0;
  logic        ifmap_ready = 1'b0;
  logic        in_ready;
  logic [7:0]  ifmap;
  logic        ifmap_enable;
  logic        busy;
  logic        done;
`ifdef IFMAP_TX_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  ifmap_tx #(
    .DATA_SIZE    (8),
    .IFMAP_NUM    (1),
    .FIFO_DEPTH   (DEPTH),
    .CONFIG_W_BIT (12)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .start        (start),
    .config_W     (config_W),
    .ifmap        (ifmap),
    .ifmap_enable (ifmap_enable),
    .ifmap_ready  (ifmap_ready),
    .busy         (busy),
    .done         (done)
`ifdef IFMAP_TX_XFER_CNT_EN
    ,
    .xfer_cnt     (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] mq[$];
  int         m_mode = M_IDLE;
  int         m_rem  = 0;
  int         m_cnt  = 0;
  bit         m_init = 1'b0;

  logic [7:0] obs[$];
  logic [7:0] stall[$];
  int         n_done   = 0;
  int         n_en     = 0;
  int         beat_cyc = -1;
  int         done_cyc = -1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: FIFO as a queue, transfer as a beat budget; advances on every clock edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      m_mode = M_IDLE;
      m_rem  = 0;
      m_cnt  = 0;
      m_init = 1'b1;
    end else if (m_init) begin
      bit b;
      bit p;
      b = (m_mode == M_SEND) && (mq.size() > 0) && (ifmap_ready == 1'b1);
      p = (in_valid == 1'b1) && (mq.size() < DEPTH);
      if (b) begin
        void'(mq.pop_front());
        m_cnt = (m_cnt + 1) % 65536;
      end
      if (p) mq.push_back(in_data);
      case (m_mode)
        M_IDLE: if (start) begin
          if (config_W == 12'd0) m_mode = M_DONE;
          else begin
            m_mode = M_SEND;
            m_rem  = int'(config_W);
          end
        end
        M_SEND: if (b) begin
          m_rem--;
          if (m_rem == 0) m_mode = M_DONE;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Per-cycle compare against the model, plus a log of beats/stalls/done for directed checks.
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      logic e_rdy;
      logic e_en;
      logic e_busy;
      logic e_done;
      e_rdy  = rst || (mq.size() < DEPTH);
      e_en   = !rst && (m_mode == M_SEND) && (mq.size() > 0);
      e_busy = !rst && (m_mode == M_SEND);
      e_done = !rst && (m_mode == M_DONE);
      checkOutput("in_ready", 32'(in_ready), 32'(e_rdy));
      checkOutput("ifmap_enable", 32'(ifmap_enable), 32'(e_en));
      checkOutput("busy", 32'(busy), 32'(e_busy));
      checkOutput("done", 32'(done), 32'(e_done));
      if (e_en) checkOutput("ifmap", 32'(ifmap), 32'(mq[0]));
`ifdef IFMAP_TX_XFER_CNT_EN
      checkOutput("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
      if (ifmap_enable === 1'b1) n_en++;
      if (ifmap_enable === 1'b1 && ifmap_ready === 1'b1) begin
        obs.push_back(ifmap);
        beat_cyc = cyc;
      end
      if (ifmap_enable === 1'b1 && ifmap_ready === 1'b0) stall.push_back(ifmap);
      if (done === 1'b1) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic s,
                               input logic [11:0] cfg, input logic rdy);
    in_valid    = v;
    in_data     = d;
    start       = s;
    config_W    = cfg;
    ifmap_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    obs.delete();
    stall.delete();
    n_done   = 0;
    n_en     = 0;
    beat_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic pushWords(input int first, input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 8'(first + k), 1'b0, 12'd0, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'd0, 1'b0, 12'd0, rdy);
  endtask

  task automatic waitDone(input logic rdy, input int max);
    int k;
    k = 0;
    while (n_done == 0 && k < max) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 12'd0, rdy);
      k++;
    end
    checkOutput("done_seen", 32'(n_done != 0), 32'd1);
  endtask

  task automatic checkSeq(input string name, input logic [7:0] act[$], input logic [7:0] exp[$]);
    checkOutput({name, "_len"}, 32'(act.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      checkOutput(name, (i < act.size()) ? 32'(act[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] e[$];
    int sc;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_enable", 32'(ifmap_enable), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
`ifdef IFMAP_TX_XFER_CNT_EN
    checkOutput("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif

    // Basic transfer: five back-to-back beats 1..5, done one cycle after the last beat.
    clearLog();
    pushWords(1, 5);
    applyStimulus(1'b0, 8'd0, 1'b1, 12'd5, 1'b1);
    waitDone(1'b1, 40);
    idle(3, 1'b1);
    e = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    checkSeq("t1_data", obs, e);
    checkOutput("t1_done_count", 32'(n_done), 32'd1);
    checkOutput("t1_done_lat", 32'(done_cyc - beat_cyc), 32'd1);

    // Backpressure: ready 1,0,0,1 then 1; the stalled word must be held.
    clearLog();
    pushWords(10, 3);
    applyStimulus(1'b0, 8'd0, 1'b1, 12'd3, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 12'd0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 12'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 12'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 12'd0, 1'b1);
    waitDone(1'b1, 40);
    idle(3, 1'b1);
    e = {8'd10, 8'd11, 8'd12};
    checkSeq("t2_data", obs, e);
    e = {8'd11, 8'd11};
    checkSeq("t2_stall", stall, e);
    checkOutput("t2_done_count", 32'(n_done), 32'd1);

    // FIFO full: 16 words fill it, a 17th is dropped, then drain all 16 in order.
    clearLog();
    pushWords(1, 16);
    checkOutput("t3_full_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 8'd99, 1'b0, 12'd0, 1'b0);
    checkOutput("t3_17th_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b1, 12'd16, 1'b1);
    waitDone(1'b1, 60);
    idle(2, 1'b1);
    e = {};
    for (int i = 1; i <= 16; i++) e.push_back(8'(i));
    checkSeq("t3_data", obs, e);
    checkOutput("t3_ready_back", 32'(in_ready), 32'd1);

    // Zero-length transfer leaves staged words untouched for the next transfer.
    clearLog();
    pushWords(7, 2);
    sc = cyc;
    applyStimulus(1'b0, 8'd0, 1'b1, 12'd0, 1'b1);
    waitDone(1'b1, 10);
    idle(3, 1'b1);
    checkOutput("t4_done_lat", 32'(done_cyc - sc), 32'd1);
    checkOutput("t4_no_enable", 32'(n_en), 32'd0);
    checkOutput("t4_done_count", 32'(n_done), 32'd1);
    clearLog();
    applyStimulus(1'b0, 8'd0, 1'b1, 12'd2, 1'b1);
    waitDone(1'b1, 20);
    idle(2, 1'b1);
    e = {8'd7, 8'd8};
    checkSeq("t4_retained", obs, e);

    // Reset after two of eight beats: abort, discard, no done.
    clearLog();
    pushWords(21, 8);
    applyStimulus(1'b0, 8'd0, 1'b1, 12'd8, 1'b1);
    idle(2, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0, 12'd0, 1'b1);
    rst = 1'b0;
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_enable", 32'(ifmap_enable), 32'd0);
    checkOutput("t5_in_ready", 32'(in_ready), 32'd1);
`ifdef IFMAP_TX_XFER_CNT_EN
    checkOutput("t5_xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif
    idle(3, 1'b1);
    checkOutput("t5_no_done", 32'(n_done), 32'd0);
    e = {8'd21, 8'd22};
    checkSeq("t5_partial", obs, e);
    clearLog();
    pushWords(50, 1);
    applyStimulus(1'b0, 8'd0, 1'b1, 12'd1, 1'b1);
    waitDone(1'b1, 20);
    idle(2, 1'b1);
    e = {8'd50};
    checkSeq("t5_after_rst", obs, e);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ifmap_tx.md
IFMAP_TX -- requirements
Module: ifmap_tx

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, bits per ifmap word.
REQ-002 SHALL have parameter IFMAP_NUM, default 1, words per beat; beat width W = IFMAP_NUM*DATA_SIZE.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, staging FIFO entries; power of two, at least 2.
REQ-004 SHALL have parameter CONFIG_W_BIT, default 12, width of the beat-count config.
REQ-005 SHALL have port clk, input, 1, the only clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1, upstream (GLB) push request.
REQ-008 SHALL have port in_data, input, W, upstream push data.
REQ-009 SHALL have port in_ready, output, 1, FIFO can accept data.
REQ-010 SHALL have port start, input, 1, begin one transfer.
REQ-011 SHALL have port config_W, input, CONFIG_W_BIT, beats per transfer; sampled when start is accepted.
REQ-012 SHALL have port ifmap, output, W, data to the PE.
REQ-013 SHALL have port ifmap_enable, output, 1, ifmap is valid.
REQ-014 SHALL have port ifmap_ready, input, 1, PE accepts ifmap.
REQ-015 SHALL have port busy, output, 1, transfer in progress.
REQ-016 SHALL have port done, output, 1, one-cycle transfer-complete pulse.

Function
REQ-017 SHALL use FSM states IDLE, SEND and DONE.
REQ-018 SHALL accept start only in IDLE; start in SEND or DONE is ignored.
REQ-019 SHALL go IDLE->SEND on an accepted start with config_W!=0, loading remaining=config_W.
REQ-020 SHALL go IDLE->DONE on an accepted start with config_W==0; no beats are sent.
REQ-021 SHALL define a beat as ifmap_enable & ifmap_ready on a clock edge; each beat pops one FIFO entry and decrements remaining.
REQ-022 SHALL drive ifmap_enable = (state==SEND) & FIFO not empty, combinationally; ifmap = FIFO head.
REQ-023 SHALL hold ifmap stable while ifmap_enable is high and ifmap_ready is low.
REQ-024 SHALL go SEND->DONE on the beat where remaining==1.
REQ-025 SHALL stay in DONE exactly one cycle with done=1, then return to IDLE.
REQ-026 SHALL drive busy=1 in SEND only.
REQ-027 SHALL push in_data when in_valid & in_ready; in_ready = FIFO not full, independent of state.
REQ-028 SHALL allow push and pop in the same cycle when the FIFO is neither empty nor full; occupancy is then unchanged.
REQ-029 SHALL NOT bypass data: a word pushed into an empty FIFO appears on ifmap at the earliest the next cycle.
REQ-030 SHALL deassert in_ready when the FIFO is full, even if a pop happens in the same cycle.
REQ-031 SHALL retain FIFO entries left over after DONE for the next transfer.
REQ-032 SHALL treat the FIFO read and write pointers as log2(FIFO_DEPTH)+1 bits, wrapping naturally.

Reset
REQ-033 SHALL on rst force state=IDLE, clear the FIFO pointers and clear remaining.
REQ-034 SHALL hold these output values during and after reset: ifmap_enable=0, busy=0, done=0, in_ready=1.
REQ-035 SHALL, on rst asserted mid-transfer, abort the transfer, discard FIFO contents and generate no done pulse.

Configuration
REQ-036 SHALL support the macro IFMAP_TX_XFER_CNT_EN.
REQ-037 SHALL, with IFMAP_TX_XFER_CNT_EN defined, add output xfer_cnt[15:0]: total beats since reset, cleared by rst, wrapping from 0xFFFF to 0.
REQ-038 SHALL, with IFMAP_TX_XFER_CNT_EN undefined, omit the xfer_cnt port and its logic entirely.

Structure
REQ-039 SHALL place the FSM state enum and the default DATA_SIZE and CONFIG_W_BIT constants in shared package pe_pkg.
REQ-040 SHALL implement the FIFO as sub-module sync_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, head).

Verification
REQ-041 SHALL cover basic transfer: push 5 words (1..5), start with config_W=5, ifmap_ready=1 -> 5 beats on consecutive cycles with data 1..5, then a single done pulse one cycle after the last beat.
REQ-042 SHALL cover backpressure: ifmap_ready toggling 1,0,0,1 with config_W=3 -> ifmap held stable while ready is low, exactly 3 beats, then done.
REQ-043 SHALL cover FIFO boundaries: 16 pushes with no transfer -> in_ready=0, and a 17th push is ignored; start with config_W=16 -> words 1..16 in order and in_ready returns to 1.
REQ-044 SHALL cover the zero-length case: start with config_W=0 -> done one cycle later, no ifmap_enable, and FIFO occupancy unchanged.
REQ-045 SHALL cover reset mid-transfer: rst asserted after 2 of 8 beats -> next cycle state IDLE, FIFO empty, ifmap_enable=0, no done pulse, xfer_cnt=0 (when IFMAP_TX_XFER_CNT_EN is defined).
